// File: rtl/moving_average_stream_types.sv
// Shared types and default configuration for the moving-average stream filter.
// Sizes here describe the default build (8-bit samples, 16-deep window).
package moving_average_stream_types;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_LOG2_DEPTH = 4;
    localparam int unsigned DEPTH          = 2 ** DEF_LOG2_DEPTH;
    localparam int unsigned SUM_W          = DEF_DATA_W + DEF_LOG2_DEPTH;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;
    typedef logic signed [SUM_W-1:0]      sum_t;
    typedef sample_t [DEPTH-1:0]          window_t;

    typedef struct packed {
        window_t                   window;
        sum_t                      sum;
        logic [DEF_LOG2_DEPTH-1:0] wr_ptr;
        logic [DEF_LOG2_DEPTH:0]   fill;
    } state_t;

    function automatic logic [$bits(window_t)-1:0] window_to_bits(input window_t w);
        return w;
    endfunction

    function automatic logic [$bits(state_t)-1:0] state_to_bits(input state_t s);
        return s;
    endfunction

endpackage

// File: rtl/moving_average_window.sv
// Circular sample buffer for the moving-average filter: tracks the write
// pointer and fill level, and exposes the sample about to be overwritten.
module moving_average_window
    import moving_average_stream_types::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LOG2_DEPTH = DEF_LOG2_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     flush,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [DATA_W-1:0] evicted,
    output logic                     full
);

    localparam int unsigned        WIN_DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH + 1)'(WIN_DEPTH);

    logic [WIN_DEPTH-1:0][DATA_W-1:0] win_q, win_d;
    logic [LOG2_DEPTH-1:0]            wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH:0]              fill_q, fill_d;

    assign evicted = win_q[wr_ptr_q];
    assign full    = (fill_q == FILL_MAX);

    // Next window state: flush first, then a push lands on the (possibly fresh) window.
    always_comb begin
        win_d    = win_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (flush) begin
            win_d    = '0;
            wr_ptr_d = '0;
            fill_d   = '0;
        end
        if (push) begin
            win_d[wr_ptr_d] = data;
            wr_ptr_d        = wr_ptr_d + LOG2_DEPTH'(1);
            if (fill_d != FILL_MAX) begin
                fill_d = fill_d + (LOG2_DEPTH + 1)'(1);
            end
        end
    end

    // Window state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q    <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            win_q    <= win_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/moving_average_stream.sv
// Streaming moving average over the last 2**LOG2_DEPTH accepted samples.
// Running sum is updated incrementally; output is registered one cycle later.
// Define MOVING_AVERAGE_STREAM_ROUND_EN for round-half-up (saturating) output
// instead of the default floor shift.
module moving_average_stream
    import moving_average_stream_types::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LOG2_DEPTH = DEF_LOG2_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     clear,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     window_full
);

    localparam int unsigned ACC_W = DATA_W + LOG2_DEPTH;

    logic signed [DATA_W-1:0] evicted;
    logic                     full;
    logic signed [ACC_W-1:0]  in_ext, ev_ext;
    logic signed [ACC_W-1:0]  sum_q, sum_d;
    logic signed [DATA_W-1:0] avg;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q;

    moving_average_window #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .flush   (clear),
        .data    (in_data),
        .evicted (evicted),
        .full    (full)
    );

    assign in_ext = {{LOG2_DEPTH{in_data[DATA_W-1]}}, in_data};
    assign ev_ext = {{LOG2_DEPTH{evicted[DATA_W-1]}}, evicted};

    // Next running sum; on clear+push the evicted slot is part of the flushed window, so it contributes nothing.
    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = '0;
        end
        if (in_valid) begin
            if (clear) begin
                sum_d = in_ext;
            end else begin
                sum_d = sum_q + in_ext - ev_ext;
            end
        end
    end

`ifdef MOVING_AVERAGE_STREAM_ROUND_EN
    localparam logic signed [ACC_W:0] HALF    = (ACC_W + 1)'(2 ** (LOG2_DEPTH - 1));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(2 ** (DATA_W - 1) - 1);

    logic signed [ACC_W:0] rnd_sum, rnd_shift;

    // Round half up with one guard bit; only the positive end can exceed the sample range.
    always_comb begin
        rnd_sum   = {sum_d[ACC_W-1], sum_d} + HALF;
        rnd_shift = rnd_sum >>> LOG2_DEPTH;
        if (rnd_shift > SAT_MAX) begin
            avg = {1'b0, {(DATA_W - 1){1'b1}}};
        end else begin
            avg = rnd_shift[DATA_W-1:0];
        end
    end
`else
    // Floor average: arithmetic shift always fits the sample width.
    always_comb begin
        avg = DATA_W'(sum_d >>> LOG2_DEPTH);
    end
`endif

    // Output data holds its last value when nothing is accepted.
    always_comb begin
        out_data_d = out_data_q;
        if (in_valid) begin
            out_data_d = avg;
        end
    end

    // Sum and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            sum_q       <= sum_d;
            out_valid_q <= in_valid;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign window_full = full;

endmodule

// File: tb/tb_moving_average_stream.sv
// Scoreboard bench for moving_average_stream (default 8-bit, 16-deep window).
// Honours MOVING_AVERAGE_STREAM_ROUND_EN in its expected values.
module tb_moving_average_stream;

    localparam int D = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              clear;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic              window_full;

    typedef struct {
        int    data;
        bit    full;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int win[D];
    int wptr;
    int fill;
    int sum;

    moving_average_stream #(
        .DATA_W     (8),
        .LOG2_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .window_full (window_full)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(input int s);
        if (s >= 0) return s / D;
        return -((-s + D - 1) / D);
    endfunction

    function automatic int expect_avg(input int s);
`ifdef MOVING_AVERAGE_STREAM_ROUND_EN
        int r;
        r = floor_div(s + D / 2);
        if (r > 127) r = 127;
        return r;
`else
        return floor_div(s);
`endif
    endfunction

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) win[i] = 0;
        wptr = 0;
        fill = 0;
        sum  = 0;
    endtask

    task automatic send(input int d, input bit clr, input string nm);
        exp_t e;
        @(negedge clk);
        if (clr) model_reset();
        sum       = sum + d - win[wptr];
        win[wptr] = d;
        wptr      = (wptr + 1) % D;
        if (fill < D) fill++;
        e.data = expect_avg(sum);
        e.full = (fill == D);
        e.name = nm;
        exp_q.push_back(e);
        in_valid = 1'b1;
        in_data  = 8'(d);
        clear    = clr;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    // Monitor: every output pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected out_valid: got data %0d, expected no output", out_data);
            end else begin
                e = exp_q.pop_front();
                check({e.name, " data"}, int'(out_data), e.data);
                check({e.name, " full"}, int'(window_full), int'(e.full));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        in_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_data", int'(out_data), 0);
        check("reset window_full", int'(window_full), 0);
        rst = 1'b0;

        // Ramp: 16 x +16 gives 1..16, then a 0 evicts one 16 -> 15
        for (int k = 0; k < 16; k++) send(16, 1'b0, "ramp");
        send(0, 1'b0, "ramp evict");
        idle();

        // Extremes: fresh window of +127, then overwrite with -128
        send(127, 1'b1, "max first");
        for (int k = 0; k < 15; k++) send(127, 1'b0, "max");
        for (int k = 0; k < 16; k++) send(-128, 1'b0, "min");
        idle();
        @(negedge clk);
        check("min final data", int'(out_data), -128);

        // Clear alone: no output pulse, data held, window emptied
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        check("clear out_valid", int'(out_valid), 0);
        check("clear window_full", int'(window_full), 0);
        check("clear holds data", int'(out_data), -128);

        // Single -1 into an empty window: floor gives -1, rounding gives 0
        send(-1, 1'b0, "neg one");
        idle();

        // 8 x 127 + 8 x 126 = 2024: floor 126, rounded 127
        send(127, 1'b1, "mix first");
        for (int k = 0; k < 7; k++) send(127, 1'b0, "mix 127");
        for (int k = 0; k < 8; k++) send(126, 1'b0, "mix 126");
        idle();

        // Mid-window clear with a sample: 32 -> 2, then 15 more -> 32 and full
        for (int k = 0; k < 5; k++) send(20, 1'b0, "pre clear");
        send(32, 1'b1, "clear load");
        for (int k = 0; k < 15; k++) send(32, 1'b0, "refill");

        // Asynchronous reset while streaming
        for (int k = 0; k < 3; k++) send(16, 1'b0, "pre reset");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", int'(out_valid), 0);
        check("async rst out_data", int'(out_data), 0);
        check("async rst window_full", int'(window_full), 0);
        in_valid = 1'b0;
        clear    = 1'b0;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send(16, 1'b0, "post reset");
        idle();

        repeat (3) @(negedge clk);
        check("pending expectations", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
